touch_event_decoder: RTL and testbench

Consumer end of the capacitive sensor array's 288-bit `readings` bus. It snapshots all nine 32-bit charge counts once per sensing period and learns a per-pad baseline during a calibration phase. It then scans the pads serially, one per cycle, and turns the counts into debounced per-pad `touched` levels plus single-cycle hit events (`hit_valid`/`hit_index`) for the game logic.

---
 rtl/touch_event_decoder.sv | 168 ++++++++++++++++
 tb/tb_touch_event_decoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/touch_event_decoder.sv
// Capacitive touch decoder: snapshots nine 32-bit pad counts once per sensing
// period, learns per-pad baselines, then scans pads serially to produce
// debounced touch levels and single-cycle hit events.
module touch_event_decoder #(
  parameter logic [16:0] SAMPLE_PERIOD = 17'd100002,
  parameter int unsigned CAL_LOG2      = 3,
  parameter logic [31:0] TOUCH_DELTA   = 32'd200,
  parameter logic [31:0] RELEASE_DELTA = 32'd100,
  parameter logic [1:0]  DEBOUNCE      = 2'd2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [287:0] readings,
  output logic [8:0]   touched,
  output logic         hit_valid,
  output logic [3:0]   hit_index,
  output logic         calibrated
);

  localparam int unsigned NPAD   = 9;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned SUM_W  = CNT_W + CAL_LOG2;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned PCNT_W = 17;
  localparam int unsigned CALC_W = CAL_LOG2 + 1;
  localparam int unsigned DEB_W  = 2;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NPAD - 1);
  localparam logic [CALC_W-1:0] CAL_SCANS = CALC_W'(2 ** CAL_LOG2);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [PCNT_W-1:0]     pcnt_q;
  logic                  launch_c;
  logic [CNT_W-1:0]      snap_q [NPAD];
  logic [SUM_W-1:0]      sum_q [NPAD];
  logic [CNT_W-1:0]      base_q [NPAD];
  logic [DEB_W-1:0]      deb_q [NPAD];
  logic [DEB_W-1:0]      deb_d [NPAD];
  logic [NPAD-1:0]       touched_q, touched_d;
  logic                  hit_valid_q, hit_valid_d;
  logic [IDX_W-1:0]      hit_index_q, hit_index_d;
  logic                  cal_q;
  logic [CALC_W-1:0]     cal_cnt_q;
  logic                  scan_done_q;

  logic [CNT_W-1:0]      pad_c;
  logic [CNT_W-1:0]      base_c;
  logic [CNT_W-1:0]      delta_c;
  logic [DEB_W-1:0]      deb_inc_c;

  assign launch_c = (pcnt_q == SAMPLE_PERIOD - PCNT_W'(1));

  // Current pad under scan and its saturating rise above baseline.
  always_comb begin
    pad_c     = snap_q[idx_q];
    base_c    = base_q[idx_q];
    delta_c   = (pad_c > base_c) ? (pad_c - base_c) : '0;
    deb_inc_c = deb_q[idx_q] + DEB_W'(1);
  end

  // Scan sequencing and per-pad touch/debounce decision.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    touched_d   = touched_q;
    deb_d       = deb_q;
    hit_valid_d = 1'b0;
    hit_index_d = hit_index_q;
    case (state_q)
      IDLE: begin
        if (launch_c) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
        if (cal_q) begin
          if (!touched_q[idx_q]) begin
            if (delta_c >= TOUCH_DELTA) begin
              if (deb_inc_c == DEBOUNCE) begin
                touched_d[idx_q] = 1'b1;
                deb_d[idx_q]     = '0;
                hit_valid_d      = 1'b1;
                hit_index_d      = idx_q;
              end else begin
                deb_d[idx_q] = deb_inc_c;
              end
            end else begin
              deb_d[idx_q] = '0;
            end
          end else if (delta_c < RELEASE_DELTA) begin
            touched_d[idx_q] = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // FSM, period counter and touch-state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      pcnt_q      <= '0;
      touched_q   <= '0;
      hit_valid_q <= 1'b0;
      hit_index_q <= '0;
      for (int i = 0; i < NPAD; i++) deb_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pcnt_q      <= launch_c ? '0 : pcnt_q + PCNT_W'(1);
      touched_q   <= touched_d;
      hit_valid_q <= hit_valid_d;
      hit_index_q <= hit_index_d;
      deb_q       <= deb_d;
    end
  end

  // Snapshot capture, calibration accumulation and baseline latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      cal_q       <= 1'b0;
      cal_cnt_q   <= '0;
      scan_done_q <= 1'b0;
      for (int i = 0; i < NPAD; i++) begin
        snap_q[i] <= '0;
        sum_q[i]  <= '0;
        base_q[i] <= '0;
      end
    end else begin
      scan_done_q <= (state_q == SCAN) && (idx_q == LAST_IDX);
      if (launch_c) begin
        for (int i = 0; i < NPAD; i++) snap_q[i] <= readings[32*i +: 32];
      end
      if ((state_q == SCAN) && !cal_q) begin
        sum_q[idx_q] <= sum_q[idx_q] + SUM_W'(pad_c);
        if (idx_q == LAST_IDX) cal_cnt_q <= cal_cnt_q + CALC_W'(1);
      end
      if (scan_done_q && !cal_q && (cal_cnt_q == CAL_SCANS)) begin
        cal_q <= 1'b1;
        for (int i = 0; i < NPAD; i++) base_q[i] <= CNT_W'(sum_q[i] >> CAL_LOG2);
      end
    end
  end

  assign touched    = touched_q;
  assign hit_valid  = hit_valid_q;
  assign hit_index  = hit_index_q;
  assign calibrated = cal_q;

endmodule

// File: tb/tb_touch_event_decoder.sv
// Directed bench for touch_event_decoder with a 20-cycle sensing period.
module tb_touch_event_decoder;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [287:0] readings = '0;
  logic [8:0]   touched;
  logic         hit_valid;
  logic [3:0]   hit_index;
  logic         calibrated;

  int n_checks = 0;
  int n_fail   = 0;
  int tb_pcnt  = 0;

  touch_event_decoder #(
    .SAMPLE_PERIOD (17'd20),
    .CAL_LOG2      (2),
    .TOUCH_DELTA   (32'd200),
    .RELEASE_DELTA (32'd100),
    .DEBOUNCE      (2'd2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .readings   (readings),
    .touched    (touched),
    .hit_valid  (hit_valid),
    .hit_index  (hit_index),
    .calibrated (calibrated)
  );

  always #5 clock = ~clock;

  // Bench's own view of the sensing period, used to find snapshot cycles.
  always @(posedge clock) begin
    if (reset) tb_pcnt <= 0;
    else       tb_pcnt <= (tb_pcnt == 19) ? 0 : tb_pcnt + 1;
  end

  function automatic logic [287:0] fill(input logic [31:0] v);
    logic [287:0] r;
    for (int i = 0; i < 9; i++) r[32*i +: 32] = v;
    return r;
  endfunction

  function automatic logic [287:0] setpad(input logic [287:0] r, input int p, input logic [31:0] v);
    logic [287:0] o;
    o = r;
    o[32*p +: 32] = v;
    return o;
  endfunction

  // Drive readings during the cycle whose closing edge latches the snapshot.
  task automatic snap(input logic [287:0] r);
    int k;
    k = 0;
    while (tb_pcnt != 19 && k < 40) begin
      @(negedge clock);
      k++;
    end
    if (k >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL snap_wait: snapshot cycle not reached within 40 cycles");
    end
    readings = r;
  endtask

  // Walk the 11 cycles after a snapshot checking hits, touched and calibrated.
  task automatic scan_check(input string name, input logic [8:0] mask, input logic [8:0] exp_t,
                            input logic cal10, input logic cal11);
    logic exp_hv;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clock);
      if (n == 1) readings = fill(32'd5000);
      exp_hv = (n >= 2 && n <= 10) ? mask[n-2] : 1'b0;
      n_checks++;
      if (hit_valid !== exp_hv) begin
        n_fail++;
        $display("FAIL %s hit_valid@+%0d: got %b want %b", name, n, hit_valid, exp_hv);
      end
      if (exp_hv) begin
        n_checks++;
        if (hit_index !== 4'(n - 2)) begin
          n_fail++;
          $display("FAIL %s hit_index@+%0d: got %0d want %0d", name, n, hit_index, n - 2);
        end
      end
      if (n == 10) begin
        n_checks++;
        if (calibrated !== cal10) begin
          n_fail++;
          $display("FAIL %s calibrated@+10: got %b want %b", name, calibrated, cal10);
        end
      end
      if (n == 11) begin
        n_checks++;
        if (calibrated !== cal11) begin
          n_fail++;
          $display("FAIL %s calibrated@+11: got %b want %b", name, calibrated, cal11);
        end
        n_checks++;
        if (touched !== exp_t) begin
          n_fail++;
          $display("FAIL %s touched: got %h want %h", name, touched, exp_t);
        end
      end
    end
  endtask

  task automatic check_outputs_zero(input string name);
    n_checks++;
    if (touched !== 9'h000) begin
      n_fail++;
      $display("FAIL %s touched: got %h want 000", name, touched);
    end
    n_checks++;
    if (hit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s hit_valid: got %b want 0", name, hit_valid);
    end
    n_checks++;
    if (hit_index !== 4'd0) begin
      n_fail++;
      $display("FAIL %s hit_index: got %0d want 0", name, hit_index);
    end
    n_checks++;
    if (calibrated !== 1'b0) begin
      n_fail++;
      $display("FAIL %s calibrated: got %b want 0", name, calibrated);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_outputs_zero("reset");
    reset = 1'b0;
  endtask

  // Four snapshots 1000..1003 average to baseline 1001.
  task automatic test_calibration();
    for (int k = 0; k < 4; k++) begin
      snap(fill(32'(1000 + k)));
      scan_check("cal", 9'h000, 9'h000, 1'b0, (k == 3));
    end
  endtask

  task automatic test_debounce();
    logic [287:0] base_r;
    logic [287:0] hot_r;
    base_r = fill(32'd1001);
    hot_r  = setpad(base_r, 4, 32'd1201);
    snap(hot_r);
    scan_check("deb_single", 9'h000, 9'h000, 1'b1, 1'b1);
    snap(base_r);
    scan_check("deb_back", 9'h000, 9'h000, 1'b1, 1'b1);
    snap(hot_r);
    scan_check("deb_first", 9'h000, 9'h000, 1'b1, 1'b1);
    snap(hot_r);
    scan_check("deb_hit", 9'h010, 9'h010, 1'b1, 1'b1);
  endtask

  task automatic test_hysteresis();
    logic [287:0] base_r;
    base_r = fill(32'd1001);
    snap(setpad(base_r, 4, 32'd1150));
    scan_check("hyst_149", 9'h000, 9'h010, 1'b1, 1'b1);
    snap(setpad(base_r, 4, 32'd1101));
    scan_check("hyst_100", 9'h000, 9'h010, 1'b1, 1'b1);
    snap(setpad(base_r, 4, 32'd1100));
    scan_check("hyst_99", 9'h000, 9'h000, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [287:0] r;
    r = fill(32'd1001);
    r = setpad(r, 0, 32'd1300);
    r = setpad(r, 3, 32'd1300);
    r = setpad(r, 8, 32'd1300);
    snap(r);
    scan_check("multi_first", 9'h000, 9'h000, 1'b1, 1'b1);
    snap(r);
    scan_check("multi_hit", 9'h109, 9'h109, 1'b1, 1'b1);
  endtask

  task automatic test_underflow();
    logic [287:0] r;
    r = setpad(fill(32'd1001), 5, 32'd500);
    snap(r);
    scan_check("under_1", 9'h000, 9'h000, 1'b1, 1'b1);
    snap(r);
    scan_check("under_2", 9'h000, 9'h000, 1'b1, 1'b1);
  endtask

  task automatic test_reset_midrun();
    logic [287:0] r;
    r = setpad(fill(32'd1001), 2, 32'd1300);
    snap(r);
    scan_check("pre_rst_1", 9'h000, 9'h000, 1'b1, 1'b1);
    snap(r);
    scan_check("pre_rst_2", 9'h004, 9'h004, 1'b1, 1'b1);
    snap(r);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_outputs_zero("midrun_reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      snap(fill(32'd2000));
      scan_check("recal", 9'h000, 9'h000, 1'b0, (k == 3));
    end
    r = setpad(fill(32'd2000), 1, 32'd2200);
    snap(r);
    scan_check("post_rst_1", 9'h000, 9'h000, 1'b1, 1'b1);
    snap(r);
    scan_check("post_rst_2", 9'h002, 9'h002, 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_calibration();
    test_debounce();
    test_hysteresis();
    test_back_to_back();
    test_underflow();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
